// File: rtl/aes_mc_pkg.sv
// aes_mc_pkg -- shared definitions for the MixColumns engine.
//   mc_state_e : control FSM states (IDLE / CALC / DONE)
//   GF_RED     : low byte of the AES field polynomial x^8+x^4+x^3+x+1
//   xtime()    : multiply a field element by x (i.e. by 2)
//   gf_mul()   : multiply by one of the constants used by (Inv)MixColumns
//   get_col()  : extract 32-bit column c from a 128-bit state
package aes_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    localparam logic [7:0] GF_RED = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        logic [7:0] r;
        r = {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
        return r;
    endfunction

    // Only the coefficients MixColumns/InvMixColumns need; anything else
    // yields zero so a bad coefficient shows up immediately.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2, x4, x8, r;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            4'h1:    r = a;
            4'h2:    r = x2;
            4'h3:    r = x2 ^ a;
            4'h9:    r = x8 ^ a;
            4'hB:    r = x8 ^ x2 ^ a;
            4'hD:    r = x8 ^ x4 ^ a;
            4'hE:    r = x8 ^ x4 ^ x2;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Column 0 occupies the most significant 32 bits.
    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
        return s[127 - 32*int'(c) -: 32];
    endfunction

endpackage

// File: rtl/mix_column_unit.sv
// mix_column_unit -- combinational (Inv)MixColumns on a single column.
//   col_in  [31:0] : column, row 0 in bits [31:24]
//   inv            : 0 = MixColumns, 1 = InvMixColumns
//   col_out [31:0] : transformed column, same byte order
module mix_column_unit
    import aes_mc_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [3:0][3:0] row;

    always_comb begin
        // First coefficient row; every output row is this row rotated right
        // by its own index, so b[i] uses row[(j - i) mod 4] against a[j].
        if (inv) begin
            row[0] = 4'hE; row[1] = 4'hB; row[2] = 4'hD; row[3] = 4'h9;
        end else begin
            row[0] = 4'h2; row[1] = 4'h3; row[2] = 4'h1; row[3] = 4'h1;
        end
        for (int i = 0; i < 4; i++) begin
            a[i] = col_in[31 - 8*i -: 8];
        end
        for (int i = 0; i < 4; i++) begin
            b[i] = 8'h00;
            for (int j = 0; j < 4; j++) begin
                b[i] = b[i] ^ gf_mul(a[j], row[(j - i + 4) % 4]);
            end
        end
        col_out = {b[0], b[1], b[2], b[3]};
    end

endmodule

// File: rtl/mix_columns_engine.sv
// mix_columns_engine -- iterative AES (Inv)MixColumns over a 128-bit state.
// Accepts a state in IDLE, transforms COLS_PER_CYCLE columns per CALC cycle
// in place, then holds the result in DONE until the consumer takes it.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake (ready only in IDLE)
//   in_state [127:0]      : state, byte k at [127-8k -: 8]
//   in_inv                : 0 = MixColumns, 1 = InvMixColumns (latched at accept)
//   out_valid / out_ready : output handshake (valid only in DONE)
//   out_state [127:0]     : working register, meaningful while out_valid
//   busy                  : any state other than IDLE
// COLS_PER_CYCLE must be 1, 2 or 4.
module mix_columns_engine
    import aes_mc_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    // With 4 columns per cycle the step truncates to 0, which is exactly the
    // modulo-4 wrap of the 2-bit column index.
    localparam logic [1:0] COL_STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] COL_LAST_OFS = 2'(COLS_PER_CYCLE - 1);

    mc_state_e    state_q, state_d;
    logic [1:0]   col_idx_q, col_idx_d;
    logic         inv_q, inv_d;
    logic [127:0] work_q, work_d;

    logic [COLS_PER_CYCLE-1:0][1:0]  unit_col;
    logic [COLS_PER_CYCLE-1:0][31:0] unit_in;
    logic [COLS_PER_CYCLE-1:0][31:0] unit_out;

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
        assign unit_col[g] = col_idx_q + 2'(g);
        assign unit_in[g]  = get_col(work_q, unit_col[g]);

        mix_column_unit u_mcu (
            .col_in  (unit_in[g]),
            .inv     (inv_q),
            .col_out (unit_out[g])
        );
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        inv_d     = inv_q;
        work_d    = work_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d    = in_state;
                    inv_d     = in_inv;
                    col_idx_d = 2'd0;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    work_d[127 - 32*int'(unit_col[g]) -: 32] = unit_out[g];
                end
                col_idx_d = col_idx_q + COL_STEP;
                // The cycle whose last column is column 3 finishes the state.
                if (2'(col_idx_q + COL_LAST_OFS) == 2'd3) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            col_idx_q <= 2'd0;
            inv_q     <= 1'b0;
            work_q    <= '0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            inv_q     <= inv_d;
            work_q    <= work_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_state = work_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb_mix_columns_engine -- one engine per legal COLS_PER_CYCLE (1, 2, 4),
// each checked against a plain GF(2^8) matrix model of (Inv)MixColumns.
module tb_mix_columns_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [3];
    logic         in_inv    [3];
    logic         out_ready [3];
    logic [127:0] in_state  [3];
    logic [2:0]   in_ready, out_valid, busy;
    logic [127:0] out_state [3];

    int vectors     = 0;
    int miscompares = 0;
    int ncyc        = 0;

    logic [127:0] exp_s    [3];
    bit           pend     [3] = '{0, 0, 0};
    bit           lat_done [3] = '{0, 0, 0};
    int           acc      [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_engine #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_inv    (in_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1B;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [127:0] mc_model(logic [127:0] s, logic inv);
        logic [7:0]   fw [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
        logic [7:0]   iv [4] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        logic [7:0]   a  [4];
        logic [7:0]   acc_b;
        logic [127:0] r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127 - 8*(4*c + j) -: 8];
            for (int i = 0; i < 4; i++) begin
                acc_b = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc_b = acc_b ^ gmul(a[j], inv ? iv[(j - i + 4) % 4] : fw[(j - i + 4) % 4]);
                r[127 - 8*(4*c + i) -: 8] = acc_b;
            end
        end
        return r;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    // Runs mid-cycle: checks outputs produced by the previous edge, then
    // records what the next edge will do with the current inputs.
    always @(negedge clk) begin
        ncyc++;
        for (int d = 0; d < 3; d++) begin
            if (out_valid[d] === 1'b1) begin
                if (!pend[d]) begin
                    chk($sformatf("spurious_out_valid[%0d]", d), 128'(out_valid[d]), 128'd0);
                end else begin
                    chk($sformatf("sb_out_state[%0d]", d), out_state[d], exp_s[d]);
                    chk($sformatf("in_ready_in_done[%0d]", d), 128'(in_ready[d]), 128'd0);
                    if (!lat_done[d]) begin
                        chk($sformatf("latency[%0d]", d), 128'(ncyc - acc[d]), 128'(4 / (1 << d) + 1));
                        lat_done[d] = 1'b1;
                    end
                end
            end
            if (rst) begin
                pend[d] = 1'b0;
            end else if (in_valid[d] && in_ready[d] === 1'b1) begin
                exp_s[d]    = mc_model(in_state[d], in_inv[d]);
                pend[d]     = 1'b1;
                acc[d]      = ncyc;
                lat_done[d] = 1'b0;
            end else if (out_valid[d] === 1'b1 && out_ready[d]) begin
                pend[d] = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge + #1) ----------------
    task automatic send(int d, logic [127:0] s, logic inv);
        int t = 0;
        in_state[d] = s;
        in_inv[d]   = inv;
        in_valid[d] = 1'b1;
        while (in_ready[d] !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (in_ready[d] !== 1'b1) chk($sformatf("send_timeout[%0d]", d), 128'(in_ready[d]), 128'd1);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_valid(int d);
        int t = 0;
        while (out_valid[d] !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (out_valid[d] !== 1'b1) chk($sformatf("out_timeout[%0d]", d), 128'(out_valid[d]), 128'd1);
    endtask

    // Assumes out_ready[d]=1: the handshake completes on the next edge.
    task automatic recv(int d, output logic [127:0] r);
        wait_valid(d);
        r = out_state[d];
        @(posedge clk); #1;
    endtask

    task automatic chk_idle_reset(int d);
        chk($sformatf("rst_in_ready[%0d]", d),  128'(in_ready[d]),  128'd1);
        chk($sformatf("rst_out_valid[%0d]", d), 128'(out_valid[d]), 128'd0);
        chk($sformatf("rst_busy[%0d]", d),      128'(busy[d]),      128'd0);
        chk($sformatf("rst_out_state[%0d]", d), out_state[d],       128'd0);
    endtask

    task automatic rtrip(int d, int n);
        logic [127:0] x, y, z;
        for (int k = 0; k < n; k++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            send(d, x, 1'b0);
            recv(d, y);
            send(d, y, 1'b1);
            recv(d, z);
            chk($sformatf("round_trip[%0d]", d), z, x);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] r;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; in_inv[d] = 1'b0; out_ready[d] = 1'b1; in_state[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int d = 0; d < 3; d++) chk_idle_reset(d);

        // Forward, one column per cycle
        send(0, {4{32'hdb135345}}, 1'b0);
        recv(0, r);
        chk("fwd_db135345", r, {4{32'h8e4da1bc}});

        // Inverse
        send(0, {4{32'h8e4da1bc}}, 1'b1);
        recv(0, r);
        chk("inv_8e4da1bc", r, {4{32'hdb135345}});

        send(0, {4{32'hf20a225c}}, 1'b0);
        recv(0, r);
        chk("fwd_f20a225c", r, {4{32'h9fdc589d}});

        // Mixed columns on the 4- and 2-column engines
        send(2, 128'h01010101_c6c6c6c6_d4d4d4d5_2d26314c, 1'b0);
        recv(2, r);
        chk("mixed_cpc4", r, 128'h01010101_c6c6c6c6_d5d5d7d6_4d7ebdf8);
        send(1, 128'h01010101_c6c6c6c6_d4d4d4d5_2d26314c, 1'b0);
        recv(1, r);
        chk("mixed_cpc2", r, 128'h01010101_c6c6c6c6_d5d5d7d6_4d7ebdf8);

        // Backpressure while inputs churn
        out_ready[0] = 1'b0;
        send(0, {4{32'hdb135345}}, 1'b0);
        wait_valid(0);
        for (int k = 0; k < 10; k++) begin
            in_valid[0] = 1'b1;
            in_inv[0]   = ~in_inv[0];
            in_state[0] = {$urandom, $urandom, $urandom, $urandom};
            chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
            chk("bp_in_ready",  128'(in_ready[0]),  128'd0);
            chk("bp_out_state", out_state[0], {4{32'h8e4da1bc}});
            @(posedge clk); #1;
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_busy", 128'(busy[0]), 128'd0);

        // Reset in the second CALC cycle; also reset alongside in_valid on dut 1
        send(0, {4{32'hf20a225c}}, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid[1] = 1'b1;
        in_state[1] = {4{32'h12345678}};
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_ignores_in_valid_busy", 128'(busy[1]), 128'd0);
        in_valid[1] = 1'b0;
        chk_idle_reset(0);
        repeat (6) @(posedge clk);
        #1;
        send(0, {4{32'hdb135345}}, 1'b0);
        recv(0, r);
        chk("after_rst_fwd", r, {4{32'h8e4da1bc}});

        // Random forward/inverse round trips on all engines in parallel
        fork
            rtrip(0, 1000);
            rtrip(1, 1000);
            rtrip(2, 1000);
        join

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
